alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter OUT_REG, default 1, which adds an output register stage when set to 1 and removes it when set to 0.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have these ports:
- clk  in  1  Clock; rising edge.
- rst_n  in  1  Asynchronous reset, active low.
- in_valid  in  1  Operand and control are valid.
- in_ready  out  1  The block can accept an operation.
- x  in  WIDTH  Operand X.
- y  in  WIDTH  Operand Y.
- zx, nx, zy, ny, f, no  in  1 each  Hack ALU control bits.
- out_valid  out  1  The result is valid.
- out_ready  in  1  The consumer accepts the result.
- out  out  WIDTH  Result.
- zr  out  1  Result equals zero.
- ng  out  1  Result MSB.
- cy  out  1  Adder carry-out.
- ov  out  1  Signed overflow.

Function
REQ-005 Operand preprocessing SHALL be x1 = zx ? 0 : x, then x2 = nx ? ~x1 : x1, with the same rule applied to y using zy and ny.
REQ-006 The function stage SHALL compute r = f ? (x2 + y2) mod 2^WIDTH : (x2 & y2).
REQ-007 The final result SHALL be out = no ? ~r : r.
REQ-008 Flags SHALL be computed as follows:
- zr = (out == 0).
- ng = out[WIDTH-1].
- cy = carry-out of x2 + y2 when f = 1, else 0.
- ov = (x2[MSB] == y2[MSB]) && (sum[MSB] != x2[MSB]) when f = 1, else 0.
- cy and ov SHALL be taken before the no inversion.
REQ-009 An operation SHALL be accepted on a rising clk edge where in_valid && in_ready.
REQ-010 Stage 1 SHALL register x2, y2, f and no.
REQ-011 Stage 2 (present when OUT_REG = 1) SHALL register out, zr, ng, cy and ov.
REQ-012 Latency SHALL be 2 cycles (OUT_REG = 1) or 1 cycle (OUT_REG = 0), measured from the accept edge to out_valid = 1, when there is no backpressure.
REQ-013 Throughput SHALL be one operation per cycle while out_ready = 1.
REQ-014 Each stage SHALL hold a valid bit, and a stage SHALL advance when it is empty or when its downstream stage advances.
REQ-015 in_ready SHALL be 1 when stage 1 is empty or stage 1 advances in that cycle.
REQ-016 in_ready SHALL depend combinationally on out_ready only, never on in_valid.
REQ-017 While out_valid = 1 and out_ready = 0, out, zr, ng, cy, ov and out_valid SHALL hold stable.
REQ-018 Results SHALL leave in acceptance order with no loss or duplication; pipeline capacity is 2 (OUT_REG = 1) or 1 (OUT_REG = 0).
REQ-019 On a simultaneous accept and drain, both SHALL take effect on the same edge.
REQ-020 With in_valid = 0 and the pipeline drained, out_valid SHALL be 0.
REQ-021 When out_valid = 0, the values on out and the flags SHALL be don't-care.

Reset
REQ-022 While rst_n = 0, all valid bits SHALL clear asynchronously.
REQ-023 While rst_n = 0, out_valid SHALL be 0, and out, zr, ng, cy and ov SHALL be 0.
REQ-024 On the first edge after rst_n rises, in_ready SHALL be 1.
REQ-025 Operations in flight when reset is asserted SHALL be discarded and never presented at the output.

Structure
REQ-026 Shared package alu_pkg SHALL contain:
- the alu_ctrl_t type (packed zx, nx, zy, ny, f, no);
- named opcode constants for the 18 Hack functions (ALU_ADD, ALU_SUB_XY, ALU_ZERO, ALU_NEG1, ...);
- the alu_flags_t type (zr, ng, cy, ov).
REQ-027 A purely combinational sub-module alu_core, parametrised by WIDTH, SHALL implement REQ-005 to REQ-008.
REQ-028 alu_pipe SHALL contain only the handshake and pipeline registers.
REQ-029 alu_core SHALL be reusable standalone.

Verification (WIDTH = 16, OUT_REG = 1)
REQ-030 Add: x = 5, y = 3, ctrl 000010 (x+y) -> out = 0x0008, zr = 0, ng = 0, cy = 0, ov = 0, with out_valid = 1 exactly 2 cycles after accept.
REQ-031 Subtract: x = 3, y = 5, ctrl 010011 (x-y) -> out = 0xFFFE, ng = 1, zr = 0. Zero: ctrl 101010 -> out = 0x0000, zr = 1.
REQ-032 Overflow and carry: x = 0x7FFF, y = 1, ADD -> out = 0x8000, ov = 1, ng = 1, cy = 0. Then x = 0xFFFF, y = 1, ADD -> out = 0x0000, cy = 1, zr = 1, ov = 0.
REQ-033 Backpressure: hold out_ready = 0 for 5 cycles while driving 4 back-to-back ADDs -> in_ready falls after 2 accepts, the output holds stable, and the 4 results later emerge in order, one per cycle, once out_ready = 1.
REQ-034 Reset mid-flight: with both stages valid, pulse rst_n low between clock edges -> out_valid = 0 immediately, no stale result ever appears, and in_ready = 1 after release.
REQ-035 Random regression (10k operations, random ready/valid): every output SHALL match a reference model of REQ-005 to REQ-008 in order, at WIDTH = 8, 16 and 32 and at OUT_REG = 0 and 1.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared types and constants for the Hack-style ALU pipeline.
//           - alu_ctrl_t  : packed control word {zx, nx, zy, ny, f, no}
//           - alu_flags_t : packed result flags {zr, ng, cy, ov}
//           - ALU_*       : control words for the 18 Hack functions
//           - alu_pass_ops: builds a control word that leaves the operands
//                           untouched and only selects function / negation
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef struct packed {
        logic zx;   // zero X
        logic nx;   // invert X (after zeroing)
        logic zy;   // zero Y
        logic ny;   // invert Y (after zeroing)
        logic f;    // 1: add, 0: bitwise AND
        logic no;   // invert the result
    } alu_ctrl_t;

    typedef struct packed {
        logic zr;   // result is zero
        logic ng;   // result MSB
        logic cy;   // adder carry-out (add only)
        logic ov;   // signed overflow (add only)
    } alu_flags_t;

    localparam alu_ctrl_t ALU_ZERO   = 6'b101010;
    localparam alu_ctrl_t ALU_ONE    = 6'b111111;
    localparam alu_ctrl_t ALU_NEG1   = 6'b111010;
    localparam alu_ctrl_t ALU_X      = 6'b001100;
    localparam alu_ctrl_t ALU_Y      = 6'b110000;
    localparam alu_ctrl_t ALU_NOT_X  = 6'b001101;
    localparam alu_ctrl_t ALU_NOT_Y  = 6'b110001;
    localparam alu_ctrl_t ALU_NEG_X  = 6'b001111;
    localparam alu_ctrl_t ALU_NEG_Y  = 6'b110011;
    localparam alu_ctrl_t ALU_INC_X  = 6'b011111;
    localparam alu_ctrl_t ALU_INC_Y  = 6'b110111;
    localparam alu_ctrl_t ALU_DEC_X  = 6'b001110;
    localparam alu_ctrl_t ALU_DEC_Y  = 6'b110010;
    localparam alu_ctrl_t ALU_ADD    = 6'b000010;
    localparam alu_ctrl_t ALU_SUB_XY = 6'b010011;
    localparam alu_ctrl_t ALU_SUB_YX = 6'b000111;
    localparam alu_ctrl_t ALU_AND    = 6'b000000;
    localparam alu_ctrl_t ALU_OR     = 6'b010101;

    // Operands that have already been conditioned (zeroed/inverted) must not
    // be conditioned again, so only f and no are carried through.
    function automatic alu_ctrl_t alu_pass_ops(input logic f, input logic no);
        alu_ctrl_t c;
        c    = '0;
        c.f  = f;
        c.no = no;
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module  : alu_core
// Purpose : Purely combinational Hack ALU with carry/overflow flags.
//           Usable standalone; also exposes the conditioned operands so a
//           pipeline can register them between conditioning and function.
// Ports   : x, y   [WIDTH]  operands
//           ctrl   alu_ctrl_t control word
//           x2, y2 [WIDTH]  conditioned operands (after zero/invert)
//           out    [WIDTH]  result
//           flags  alu_flags_t {zr, ng, cy, ov}
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  alu_ctrl_t        ctrl,
    output logic [WIDTH-1:0] x2,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] out,
    output alu_flags_t       flags
);

    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] r;
    logic             carry;

    always_comb begin
        x1           = ctrl.zx ? '0 : x;
        x2           = ctrl.nx ? ~x1 : x1;
        y1           = ctrl.zy ? '0 : y;
        y2           = ctrl.ny ? ~y1 : y1;
        {carry, sum} = {1'b0, x2} + {1'b0, y2};
        r            = ctrl.f ? sum : (x2 & y2);
        out          = ctrl.no ? ~r : r;

        flags.zr     = (out == '0);
        flags.ng     = out[WIDTH-1];
        // Carry and overflow describe the adder itself, before the final
        // inversion, and are meaningless for the AND function.
        flags.cy     = ctrl.f & carry;
        flags.ov     = ctrl.f & (x2[WIDTH-1] == y2[WIDTH-1])
                              & (sum[WIDTH-1] != x2[WIDTH-1]);
    end

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// Module  : alu_pipe
// Purpose : Valid/ready pipelined Hack ALU. Stage 1 registers the conditioned
//           operands plus f/no; optional stage 2 registers result and flags.
// Ports   : clk, rst_n            clock, async active-low reset
//           in_valid / in_ready   input handshake
//           x, y [WIDTH]          operands
//           zx nx zy ny f no      Hack control bits
//           out_valid / out_ready output handshake
//           out [WIDTH], zr, ng, cy, ov  result and flags
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter bit OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             cy,
    output logic             ov
);

    alu_ctrl_t        ctrl_in;
    logic [WIDTH-1:0] x2_d;
    logic [WIDTH-1:0] y2_d;
    logic [WIDTH-1:0] unused_pre_out;
    alu_flags_t       unused_pre_flags;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_x2;
    logic [WIDTH-1:0] s1_y2;
    logic             s1_f;
    logic             s1_no;
    logic             s1_adv;
    logic             s2_adv;

    logic [WIDTH-1:0] res;
    alu_flags_t       res_flags;
    logic [WIDTH-1:0] unused_fn_x2;
    logic [WIDTH-1:0] unused_fn_y2;

    assign ctrl_in = {zx, nx, zy, ny, f, no};

    // Front instance is used only for operand conditioning.
    alu_core #(.WIDTH(WIDTH)) u_pre (
        .x     (x),
        .y     (y),
        .ctrl  (ctrl_in),
        .x2    (x2_d),
        .y2    (y2_d),
        .out   (unused_pre_out),
        .flags (unused_pre_flags)
    );

    // A stage moves when it is empty or its consumer takes its contents.
    // in_ready therefore depends only on pipeline state and out_ready.
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x2    <= '0;
            s1_y2    <= '0;
            s1_f     <= 1'b0;
            s1_no    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_x2 <= x2_d;
                s1_y2 <= y2_d;
                s1_f  <= f;
                s1_no <= no;
            end
        end
    end

    // Back instance sees already-conditioned operands.
    alu_core #(.WIDTH(WIDTH)) u_fn (
        .x     (s1_x2),
        .y     (s1_y2),
        .ctrl  (alu_pass_ops(s1_f, s1_no)),
        .x2    (unused_fn_x2),
        .y2    (unused_fn_y2),
        .out   (res),
        .flags (res_flags)
    );

    generate
        if (OUT_REG) begin : g_out_reg
            logic             s2_valid;
            logic [WIDTH-1:0] s2_out;
            alu_flags_t       s2_flags;

            assign s2_adv = !s2_valid || out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_out   <= '0;
                    s2_flags <= '0;
                end else if (s2_adv) begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_out   <= res;
                        s2_flags <= res_flags;
                    end
                end
            end

            assign out_valid = s2_valid;
            assign out       = s2_out;
            assign zr        = s2_flags.zr;
            assign ng        = s2_flags.ng;
            assign cy        = s2_flags.cy;
            assign ov        = s2_flags.ov;
        end else begin : g_no_out_reg
            assign s2_adv    = out_ready;
            assign out_valid = s1_valid;
            // Reset-cleared stage-1 registers would otherwise show zr = 1;
            // masking keeps result and flags at zero while nothing is valid.
            assign out       = s1_valid ? res : '0;
            assign zr        = s1_valid & res_flags.zr;
            assign ng        = s1_valid & res_flags.ng;
            assign cy        = s1_valid & res_flags.cy;
            assign ov        = s1_valid & res_flags.ov;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
`timescale 1ns/1ps
`default_nettype none

module tb_alu_pipe;
    import alu_pkg::*;

    localparam int NCFG  = 6;
    localparam int NRAND = 10000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic [5:0]  ctrl = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out;
    logic        zr, ng, cy, ov;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16), .OUT_REG(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .zx(ctrl[5]), .nx(ctrl[4]), .zy(ctrl[3]), .ny(ctrl[2]),
        .f(ctrl[1]), .no(ctrl[0]), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zr(zr), .ng(ng), .cy(cy), .ov(ov)
    );

    // Regression instances: widths 8/16/32, each with OUT_REG 0 and 1.
    logic        r_in_valid  [NCFG];
    logic        r_in_ready  [NCFG];
    logic        r_out_valid [NCFG];
    logic        r_out_ready [NCFG];
    logic [63:0] r_x    [NCFG];
    logic [63:0] r_y    [NCFG];
    logic [5:0]  r_ctrl [NCFG];
    logic [63:0] r_out  [NCFG];
    logic        r_zr [NCFG];
    logic        r_ng [NCFG];
    logic        r_cy [NCFG];
    logic        r_ov [NCFG];

    function automatic int cfg_w(input int g);
        return (g < 2) ? 8 : (g < 4) ? 16 : 32;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W  = (g < 2) ? 8 : (g < 4) ? 16 : 32;
        localparam bit OR = ((g % 2) == 1);
        logic [W-1:0] o_w;
        alu_pipe #(.WIDTH(W), .OUT_REG(OR)) u_rnd (
            .clk(clk), .rst_n(rst_n),
            .in_valid(r_in_valid[g]), .in_ready(r_in_ready[g]),
            .x(r_x[g][W-1:0]), .y(r_y[g][W-1:0]),
            .zx(r_ctrl[g][5]), .nx(r_ctrl[g][4]), .zy(r_ctrl[g][3]),
            .ny(r_ctrl[g][2]), .f(r_ctrl[g][1]), .no(r_ctrl[g][0]),
            .out_valid(r_out_valid[g]), .out_ready(r_out_ready[g]),
            .out(o_w), .zr(r_zr[g]), .ng(r_ng[g]), .cy(r_cy[g]), .ov(r_ov[g])
        );
        assign r_out[g] = 64'(o_w);
    end

    // Reference: integer arithmetic on masked values; overflow decided by
    // whether the true signed sum leaves the representable range.
    // Returns {zr, ng, cy, ov, result[63:0]}.
    function automatic logic [67:0] model(input int w, input logic [63:0] xi,
                                          input logic [63:0] yi, input logic [5:0] c);
        logic [63:0] mask, a, b, r;
        logic [64:0] s;
        longint      sa, sb, ss, hi, lo;
        logic        zr_e, ng_e, cy_e, ov_e;
        mask = (64'd1 << w) - 64'd1;
        a = c[5] ? 64'd0 : (xi & mask);
        if (c[4]) a = ~a & mask;
        b = c[3] ? 64'd0 : (yi & mask);
        if (c[2]) b = ~b & mask;
        s = {1'b0, a} + {1'b0, b};
        r = c[1] ? (s[63:0] & mask) : (a & b);
        if (c[0]) r = ~r & mask;
        sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        ss = sa + sb;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        ov_e = c[1] && ((ss > hi) || (ss < lo));
        cy_e = c[1] && s[w];
        zr_e = (r == 64'd0);
        ng_e = r[w-1];
        return {zr_e, ng_e, cy_e, ov_e, r};
    endfunction

    // Issues one op on the main DUT and waits (bounded) for its result.
    // lat counts edges from the accept edge (1) to the edge after which
    // out_valid is seen; -1 means the result never came.
    task automatic run_single(input logic [15:0] xi, input logic [15:0] yi,
                              input logic [5:0] ci, output logic [15:0] o,
                              output logic [3:0] fl, output int lat);
        lat = -1; o = '0; fl = '0;
        @(negedge clk);
        x = xi; y = yi; ctrl = ci; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            if (out_valid) begin
                lat = i; o = out; fl = {zr, ng, cy, ov};
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++;
        if (out !== 16'h0) begin n_fail++; $display("FAIL reset_out: got %h expected 0000", out); end
        n_tests++;
        if ({zr, ng, cy, ov} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {zr, ng, cy, ov}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_add();
        logic [15:0] o; logic [3:0] fl; int lat;
        run_single(16'd5, 16'd3, ALU_ADD, o, fl, lat);
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d expected 2", lat); end
        n_tests++;
        if (o !== 16'h0008) begin n_fail++; $display("FAIL add_out: got %h expected 0008", o); end
        n_tests++;
        if (fl !== 4'b0000) begin n_fail++; $display("FAIL add_flags: got %b expected 0000", fl); end
    endtask

    task automatic test_sub_zero();
        logic [15:0] o; logic [3:0] fl; int lat;
        logic [67:0] e;
        logic [15:0] rx, ry;
        run_single(16'd3, 16'd5, ALU_SUB_XY, o, fl, lat);
        e = model(16, 64'd3, 64'd5, ALU_SUB_XY);
        n_tests++;
        if (o !== 16'hFFFE) begin n_fail++; $display("FAIL sub_out: got %h expected fffe", o); end
        n_tests++;
        if (fl[3:2] !== 2'b01) begin n_fail++; $display("FAIL sub_zr_ng: got %b expected 01", fl[3:2]); end
        n_tests++;
        if (fl !== e[67:64]) begin n_fail++; $display("FAIL sub_flags: got %b expected %b", fl, e[67:64]); end
        rx = 16'($urandom); ry = 16'($urandom);
        run_single(rx, ry, ALU_ZERO, o, fl, lat);
        n_tests++;
        if (o !== 16'h0000) begin n_fail++; $display("FAIL zero_out: got %h expected 0000", o); end
        n_tests++;
        if (fl !== 4'b1000) begin n_fail++; $display("FAIL zero_flags: got %b expected 1000", fl); end
    endtask

    task automatic test_ovf_carry();
        logic [15:0] o; logic [3:0] fl; int lat;
        run_single(16'h7FFF, 16'h0001, ALU_ADD, o, fl, lat);
        n_tests++;
        if (o !== 16'h8000) begin n_fail++; $display("FAIL ovf_out: got %h expected 8000", o); end
        n_tests++;
        if (fl !== 4'b0101) begin n_fail++; $display("FAIL ovf_flags: got %b expected 0101", fl); end
        run_single(16'hFFFF, 16'h0001, ALU_ADD, o, fl, lat);
        n_tests++;
        if (o !== 16'h0000) begin n_fail++; $display("FAIL carry_out: got %h expected 0000", o); end
        n_tests++;
        if (fl !== 4'b1010) begin n_fail++; $display("FAIL carry_flags: got %b expected 1010", fl); end
    endtask

    task automatic test_back_to_back();
        logic [67:0] exp_q[$];
        logic [67:0] got, e;
        int k, popped, gaps;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = (k < 4);
            x = 16'(k * 1000 + 7); y = 16'(k * 3 + 1); ctrl = ALU_ADD;
            #1;
            if (c == 2) begin
                n_tests++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
            end
            if (c >= 2) begin
                got = {zr, ng, cy, ov, 48'd0, out};
                n_tests++;
                if (out_valid !== 1'b1 || exp_q.size() == 0 || got !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL bp_hold: valid %b got %h expected %h", out_valid, got,
                             (exp_q.size() > 0) ? exp_q[0] : 68'd0);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(16, 64'(x), 64'(y), ctrl));
                k++;
            end
        end
        n_tests++;
        if (k !== 2) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 2", k); end
        popped = 0; gaps = 0;
        for (int i = 0; i < 20 && popped < 4; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (k < 4);
            x = 16'(k * 1000 + 7); y = 16'(k * 3 + 1); ctrl = ALU_ADD;
            #1;
            if (out_valid) begin
                got = {zr, ng, cy, ov, 48'd0, out};
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 68'hF_FFFF_FFFF_FFFF_FFFF;
                n_tests++;
                if (got !== e) begin n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", popped, got, e); end
                popped++;
            end else begin
                gaps++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(16, 64'(x), 64'(y), ctrl));
                k++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (popped !== 4) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected 4", popped); end
        n_tests++;
        if (gaps !== 0) begin n_fail++; $display("FAIL bp_drain_gaps: got %0d expected 0", gaps); end
    endtask

    task automatic test_reset_midflight();
        int stale;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; x = 16'd1; y = 16'd2; ctrl = ALU_ADD;
        @(negedge clk);
        x = 16'd3;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_full: valid %b ready %b expected 1 0", out_valid, in_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_clear: got %b expected 0", out_valid); end
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        #0.5;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) stale++;
        end
        n_tests++;
        if (stale !== 0) begin n_fail++; $display("FAIL mid_stale: got %0d stale results expected 0", stale); end
    endtask

    task automatic test_random();
        int          sent [NCFG];
        int          recv [NCFG];
        logic        hold [NCFG];
        logic [67:0] held [NCFG];
        logic [67:0] q [NCFG][$];
        logic [67:0] got, e;
        int          cyc;
        bit          all_done;
        for (int g = 0; g < NCFG; g++) begin
            sent[g] = 0; recv[g] = 0; hold[g] = 1'b0; held[g] = '0;
        end
        cyc = 0;
        while (cyc < 60000) begin
            all_done = 1'b1;
            for (int g = 0; g < NCFG; g++) if (recv[g] < NRAND) all_done = 1'b0;
            if (all_done) break;
            @(negedge clk);
            cyc++;
            for (int g = 0; g < NCFG; g++) begin
                r_in_valid[g]  = (sent[g] < NRAND) && ($urandom_range(3) != 0);
                r_x[g]         = {$urandom, $urandom};
                r_y[g]         = {$urandom, $urandom};
                r_ctrl[g]      = 6'($urandom);
                r_out_ready[g] = ($urandom_range(3) != 0);
            end
            #1;
            for (int g = 0; g < NCFG; g++) begin
                got = {r_zr[g], r_ng[g], r_cy[g], r_ov[g], r_out[g]};
                if (hold[g]) begin
                    n_tests++;
                    if (r_out_valid[g] !== 1'b1 || got !== held[g]) begin
                        n_fail++;
                        $display("FAIL rnd_hold cfg%0d: valid %b got %h expected %h", g, r_out_valid[g], got, held[g]);
                    end
                end
                hold[g] = r_out_valid[g] && !r_out_ready[g];
                held[g] = got;
                if (r_out_valid[g] && r_out_ready[g]) begin
                    n_tests++;
                    if (q[g].size() == 0) begin
                        n_fail++;
                        $display("FAIL rnd_extra cfg%0d: got %h expected no result", g, got);
                    end else begin
                        e = q[g].pop_front();
                        if (got !== e) begin
                            n_fail++;
                            $display("FAIL rnd_result cfg%0d #%0d: got %h expected %h", g, recv[g], got, e);
                        end
                    end
                    recv[g]++;
                end
                if (r_in_valid[g] && r_in_ready[g]) begin
                    q[g].push_back(model(cfg_w(g), r_x[g], r_y[g], r_ctrl[g]));
                    sent[g]++;
                end
            end
        end
        @(negedge clk);
        for (int g = 0; g < NCFG; g++) begin
            r_in_valid[g] = 1'b0;
            n_tests++;
            if (recv[g] !== NRAND) begin
                n_fail++;
                $display("FAIL rnd_count cfg%0d: got %0d results expected %0d", g, recv[g], NRAND);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < NCFG; g++) begin
            r_in_valid[g] = 1'b0; r_out_ready[g] = 1'b1;
            r_x[g] = '0; r_y[g] = '0; r_ctrl[g] = '0;
        end
        test_reset();
        test_add();
        test_sub_zero();
        test_ovf_carry();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
